// File: rtl/imm_pkg.sv
// Shared definitions for the decode-stage immediate generator:
// format select encoding, reserved select codes and a legality helper.
package imm_pkg;

  typedef enum logic [2:0] {
    IMM_I     = 3'd0,
    IMM_S     = 3'd1,
    IMM_B     = 3'd2,
    IMM_J     = 3'd3,
    IMM_U     = 3'd4,
    IMM_SHAMT = 3'd5
  } imm_src_e;

  localparam logic [2:0] IMM_RSVD6 = 3'd6;
  localparam logic [2:0] IMM_RSVD7 = 3'd7;

  function automatic logic imm_is_legal(input logic [2:0] src);
    return (src != IMM_RSVD6) && (src != IMM_RSVD7);
  endfunction

endpackage

// File: rtl/imm_extract.sv
// Combinational immediate extraction: picks the format fields out of the
// instruction and sign-extends from instr[31] (shift amounts zero-extend).
module imm_extract
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  input  logic [2:0]      imm_src,
  output logic [XLEN-1:0] imm,
  output logic            illegal
);

  logic [31:0] imm32_s;
  logic [5:0]  shamt_s;

  // Field assembly per format; signed formats are built as 32-bit values
  // already extended from instr[31], then widened by a signed cast.
  always_comb begin
    imm32_s = 32'd0;
    imm     = {XLEN{1'b0}};
    if (XLEN == 64) begin
      shamt_s = instr[25:20];
    end else begin
      shamt_s = {1'b0, instr[24:20]};
    end
    case (imm_src)
      IMM_I: begin
        imm32_s = {{20{instr[31]}}, instr[31:20]};
        imm     = XLEN'($signed(imm32_s));
      end
      IMM_S: begin
        imm32_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
        imm     = XLEN'($signed(imm32_s));
      end
      IMM_B: begin
        imm32_s = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
        imm     = XLEN'($signed(imm32_s));
      end
      IMM_J: begin
        imm32_s = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
        imm     = XLEN'($signed(imm32_s));
      end
      IMM_U: begin
        imm32_s = {instr[31:12], 12'd0};
        imm     = XLEN'($signed(imm32_s));
      end
      IMM_SHAMT: begin
        imm = XLEN'(shamt_s);
      end
      default: begin
        imm = {XLEN{1'b0}};
      end
    endcase
    illegal = !imm_is_legal(imm_src);
  end

endmodule

// File: rtl/imm_decode_stage.sv
// Decode-stage immediate generator with a registered output stage: either a
// two-entry skid buffer (registered in_ready) or a single pass-through register.
module imm_decode_stage
  import imm_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int SKID = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [2:0]      in_imm_src,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_imm_src,
  output logic            out_illegal
);

  logic [XLEN-1:0] ext_imm_s;
  logic            ext_ill_s;

  logic [1:0]      count_r;
  logic [1:0]      count_nxt_s;
  logic            ready_en_r;
  logic            in_ready_r;

  logic [XLEN-1:0] head_imm_r;
  logic [2:0]      head_src_r;
  logic            head_ill_r;
  logic [XLEN-1:0] tail_imm_r;
  logic [2:0]      tail_src_r;
  logic            tail_ill_r;

  logic            accept_s;
  logic            drain_s;
  logic            head_load_new_s;
  logic            head_load_tail_s;
  logic            tail_load_s;

  imm_extract #(
    .XLEN(XLEN)
  ) u_extract (
    .instr   (in_instr),
    .imm_src (in_imm_src),
    .imm     (ext_imm_s),
    .illegal (ext_ill_s)
  );

  // The skid variant exposes only a register; the single-entry variant
  // lets out_ready through so it can sustain one entry per cycle.
  assign in_ready = (SKID != 0) ? in_ready_r
                                : (ready_en_r & (~out_valid | out_ready));

  assign out_valid   = (count_r != 2'd0);
  assign drain_s     = out_valid & out_ready;
  assign accept_s    = in_valid & in_ready & ~flush;
  assign out_imm     = head_imm_r;
  assign out_imm_src = head_src_r;
  assign out_illegal = head_ill_r;

  // Occupancy next-state and data-path load selects.
  always_comb begin
    count_nxt_s      = count_r;
    head_load_new_s  = 1'b0;
    head_load_tail_s = 1'b0;
    tail_load_s      = 1'b0;
    if (flush) begin
      count_nxt_s = 2'd0;
    end else begin
      case (count_r)
        2'd0: begin
          if (accept_s) begin
            count_nxt_s     = 2'd1;
            head_load_new_s = 1'b1;
          end else begin
            count_nxt_s = 2'd0;
          end
        end
        2'd1: begin
          if (accept_s && drain_s) begin
            head_load_new_s = 1'b1;
          end else if (accept_s) begin
            count_nxt_s = 2'd2;
            tail_load_s = 1'b1;
          end else if (drain_s) begin
            count_nxt_s = 2'd0;
          end else begin
            count_nxt_s = 2'd1;
          end
        end
        2'd2: begin
          // Full: in_ready is low, so only a drain can move the queue.
          if (drain_s) begin
            count_nxt_s      = 2'd1;
            head_load_tail_s = 1'b1;
          end else begin
            count_nxt_s = 2'd2;
          end
        end
        default: begin
          count_nxt_s = 2'd0;
        end
      endcase
    end
  end

  // Occupancy and ready registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r    <= 2'd0;
      ready_en_r <= 1'b0;
      in_ready_r <= 1'b0;
    end else begin
      count_r    <= count_nxt_s;
      ready_en_r <= 1'b1;
      in_ready_r <= (count_nxt_s != 2'd2);
    end
  end

  // Head (output) and tail (skid) data registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_imm_r <= {XLEN{1'b0}};
      head_src_r <= 3'd0;
      head_ill_r <= 1'b0;
      tail_imm_r <= {XLEN{1'b0}};
      tail_src_r <= 3'd0;
      tail_ill_r <= 1'b0;
    end else begin
      if (head_load_new_s) begin
        head_imm_r <= ext_imm_s;
        head_src_r <= in_imm_src;
        head_ill_r <= ext_ill_s;
      end else if (head_load_tail_s) begin
        head_imm_r <= tail_imm_r;
        head_src_r <= tail_src_r;
        head_ill_r <= tail_ill_r;
      end
      if (tail_load_s) begin
        tail_imm_r <= ext_imm_s;
        tail_src_r <= in_imm_src;
        tail_ill_r <= ext_ill_s;
      end
    end
  end

endmodule

// File: doc/imm_decode_stage.md
# imm_decode_stage

Pipelined, parametrised immediate generator for the decode stage. Accepts a 32-bit instruction plus an immediate-source select over a valid/ready handshake. Extracts and sign-extends the immediate to XLEN bits, covering all RV base formats including U-type and shift amounts. Delivers the result one cycle later through an optional two-entry skid buffer, so the decode/execute boundary can stall without a combinational ready path.

## Interface
- XLEN, 32: output immediate width; legal values 32 or 64.
- SKID, 1: 1 = two-entry skid buffer (registered ready); 0 = single output register (ready passes through combinationally).
- Clock/reset (already decided): one clock; reset is asynchronous and active-low.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous pipeline flush; discards all buffered entries.
- in_valid  in  1  input entry offered.
- in_ready  out  1  stage can accept this cycle.
- in_instr  in  32  raw instruction word.
- in_imm_src  in  3  immediate format select (imm_src_e).
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts this cycle.
- out_imm  out  XLEN  extended immediate.
- out_imm_src  out  3  format select that produced out_imm.
- out_illegal  out  1  entry used a reserved select.

## Operation
- Formats (s = instr[31], sext = replicate s up to XLEN):
  - 000 I: sext(instr[31:20]).
  - 001 S: sext({instr[31:25], instr[11:7]}).
  - 010 B: sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}).
  - 011 J: sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}).
  - 100 U: sext({instr[31:12], 12'b0}).
  - 101 SHAMT: zero-extend instr[24:20] (XLEN=32) or instr[25:20] (XLEN=64).
- Sign bit is always instr[31] for signed formats, never an intermediate bit.
- 110/111 are reserved: out_imm = 0, out_illegal = 1, and the entry flows through normally.
- Transfer occurs on valid & ready at each side. Entries leave in strict acceptance order; none is dropped or duplicated.
- SKID=1: state is an occupancy count of 0/1/2.
  - in_ready = (count != 2), derived from registers only.
  - Accept with no drain: count+1. Drain with no accept: count-1. Both at once: count unchanged, and the new entry queues behind the head.
- SKID=0: in_ready = !out_valid | out_ready.
- flush: count←0 and out_valid←0 next edge. An input offered in the same cycle is discarded even if in_ready=1.
- Reset: count 0, out_valid 0, out_imm 0, out_imm_src 0, out_illegal 0. in_ready is 0 while rst_n is low and 1 from the first cycle after release.
- Reset asserted mid-stream loses all buffered entries immediately (asynchronous).

## Timing
- Latency: accepted at edge N → out_valid=1 and data stable after edge N (visible in cycle N+1).
- Throughput: 1 entry/cycle sustained when out_ready is held high, for both SKID settings.
- SKID=1: out_ready low for k cycles with continuous input fills 2 entries, then in_ready drops one cycle after the fill. No entry is lost.
- Output data and flags are registered; out_* never change while out_valid & !out_ready.
- No combinational path from in_* to out_*. For SKID=1 there is also no path from out_ready to in_ready.

## Structure
- Package imm_pkg holds:
  - imm_src_e enum: IMM_I, IMM_S, IMM_B, IMM_J, IMM_U, IMM_SHAMT.
  - the illegal-code constants.
  - function imm_is_legal().
- Sub-module imm_extract (combinational, parameter XLEN): instr + select → immediate + illegal. The stage instantiates it once at its input.
- imm_decode_stage owns the handshake, occupancy counter, two data registers and flush/reset logic.

## Test plan
- I-type 0xFFF00093 (addi x1,x0,-1), XLEN=32 → out_imm=0xFFFFFFFF one cycle after accept. Same instruction at XLEN=64 → 0xFFFFFFFFFFFFFFFF.
- B-type 0x80000063, select 010 → out_imm=0xFFFFF000. U-type 0x12345037, select 100 → 0x12345000.
- J-type 0x0000006F with instr[31]=0 and bit 20 set (0x0010006F) → out_imm=0x00000800. Confirms bit 11 does not drive sign extension.
- Select 111 on any instruction → out_imm=0, out_illegal=1, handshake unaffected.
- SKID=1: stream 5 entries while out_ready is low for 3 cycles.
  - in_ready must fall after 2 accepts.
  - Output order must be 1..5.
  - No bubbles once out_ready returns high.
- flush with 2 entries held and in_valid=1 → next cycle out_valid=0, in_ready=1. Both held entries and the flushed input are never emitted. Mid-stream rst_n low clears out_valid asynchronously.
